cnn_conv1d: RTL
===============

# cnn_conv1d

Parametrised streaming 1-D convolution stage, the successor to the fixed 8-bit `cnn` datapath. It accepts one signed sample per `i_en` cycle, keeps a K-deep sliding window, multiplies it against K run-time-programmable signed weights, then requantises (round, shift, saturate) to produce one output sample per input once the window is full. It sits in the CNN pipeline between the sample source and the next layer, using the same `in`/`i_en` → `out`/`o_en` streaming convention.

## Interface
- `DW`, 8: signed sample width, used for both input and output.
- `WW`, 8: signed weight width.
- `K`, 3: number of taps, at least 2.
- `SHIFT`, 0: requantisation right-shift, 0..(DW+WW-1).
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-low reset.
- `in` in DW: signed input sample.
- `i_en` in 1: `in` is valid this cycle; the sample is accepted at this edge.
- `clr` in 1: synchronous flush of the window and pipeline; weights are retained.
- `w_we` in 1: weight write strobe.
- `w_addr` in max(1,$clog2(K)): tap index to write.
- `w_data` in WW: signed weight value.
- `out` out DW: signed result.
- `o_en` out 1: one-cycle valid pulse for `out`.

## Operation
- Result definition: y[n] = Σ_{k=0..K-1} w[k]·x[n−k]. Tap 0 is the newest sample.
- Accumulator width is AW = DW+WW+$clog2(K), signed, so no intermediate overflow is possible.
- Requantisation, in order:
  - Rounding: if SHIFT>0, add 2^(SHIFT−1).
  - Arithmetic right shift by SHIFT.
  - Saturation to [−2^(DW−1), 2^(DW−1)−1].
- Fill FSM:
  - States: EMPTY (no samples), FILL (1..K−1 samples), RUN (window full).
  - EMPTY→FILL on an accepted sample.
  - FILL→RUN when the K-th sample is accepted.
  - RUN is held until `clr` or reset.
  - Any state→EMPTY on `clr`.
- Output rule: only samples accepted while the window becomes or stays full produce an output. The K-th sample and every later sample each produce exactly one `o_en`. The first K−1 samples after reset or `clr` produce none.
- Weight writes:
  - `w_we` writes `w_data` to `w[w_addr]` at the edge.
  - `w_addr` ≥ K is ignored.
  - A write in the same cycle as an accepted sample takes effect for that sample.
- `clr` together with `i_en`: `clr` wins and the sample is dropped. `clr` also kills all in-flight pipeline valids, so no `o_en` follows it.
- `i_en` low: the window and FSM hold, and the pipeline drains normally.

## Timing
- Reset values:
  - `out` = 0, `o_en` = 0.
  - Window = 0, weights = 0, FSM = EMPTY.
  - All pipeline valids = 0.
- Reset is asynchronous mid-stream: in-flight results are discarded and weights must be reprogrammed.
- Pipeline, with the sample accepted at edge N:
  - Window register updated at edge N.
  - K products registered at edge N+1.
  - Sum registered at edge N+2.
  - Requantised `out` and `o_en` registered at edge N+3.
- Latency is therefore 3 cycles.
- Throughput is one sample per cycle, with no back-pressure. Back-to-back `i_en` produces back-to-back `o_en`.
- `out` holds its last value while `o_en` is low.

## Configuration
- `CNN_CONV1D_RELU_EN`:
  - Defined: a ReLU is applied after saturation, so a negative result gives `out` = 0.
  - Undefined: signed saturated results pass through unchanged.
- Latency is 3 cycles either way.

## Structure
- `cnn_pkg` holds:
  - The accumulator-width function.
  - The saturate/round function used by both RTL and bench.
  - FSM state typedef `fill_state_t` {EMPTY, FILL, RUN}.
- Sub-module `cnn_mac_tree`: registered K-way multiply, then a registered adder tree, parametrised by DW, WW and K. It provides pipeline stages 1–2.
- The top level owns the window, the weight registers, the FSM, the requantisation and the ReLU.

## Test plan
- **Basic convolution.** K=3, SHIFT=0, w={1,1,1}; samples 16, 32, 8 spaced 3 cycles apart → exactly one `o_en`, 3 cycles after the 8 is accepted, with `out`=56.
- **Back-to-back streaming.** w={1,2,3} (tap 0 = 1); stream 1,2,3,4 on consecutive cycles → `o_en` on 2 consecutive cycles, `out`=10 then 16.
- **Saturation and rounding.**
  - w={127,127,127}, inputs 127×3 → `out`=127.
  - SHIFT=2, w={1,1,1}, inputs 2,2,2 → (6+2)>>2, so `out`=2.
- **ReLU macro.** w={−1,−1,−1}, inputs 16,32,8 → `out`=0 with `CNN_CONV1D_RELU_EN`, and −56 (0xC8) without.
- **Flush.**
  - `clr` after 2 of 3 samples → no `o_en`, and the next output needs 3 fresh samples.
  - `clr` in the same cycle as `i_en` → that sample is dropped.
- **Reset mid-stream.** Assert `rst` low one cycle after an accepted sample in RUN → `o_en` and `out` go to 0 immediately, the pending result never appears, and weights read back as 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and arithmetic helpers for the cnn_conv1d streaming convolution stage.
package cnn_pkg;

  typedef enum logic [1:0] {EMPTY, FILL, RUN} fill_state_t;

  function automatic int unsigned acc_width(int unsigned dw, int unsigned ww, int unsigned k);
    return dw + ww + $clog2(k);
  endfunction

  // Round half-up, arithmetic shift, then clamp to a signed dw-bit range.
  function automatic logic signed [63:0] round_sat(logic signed [63:0] acc,
                                                   int unsigned shift, int unsigned dw);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r = acc;
    if (shift > 0) r = r + (64'sd1 <<< (shift - 1));
    r  = r >>> shift;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/cnn_mac_tree.sv
// Pipeline stages 1-2: registered K-way signed multiply, then a registered sum.
module cnn_mac_tree
  import cnn_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned WW = 8,
  parameter int unsigned K  = 3,
  localparam int unsigned AW = acc_width(DW, WW, K)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   vld_in,
  input  logic [K-1:0][DW-1:0]   win,
  input  logic [K-1:0][WW-1:0]   wts,
  output logic signed [AW-1:0]   sum,
  output logic                   vld_out
);

  localparam int unsigned PW = DW + WW;

  logic signed [PW-1:0] prod_q [K];
  logic                 prod_vld_q;
  logic signed [AW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int unsigned k = 0; k < K; k++) acc = acc + AW'(prod_q[k]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned k = 0; k < K; k++) prod_q[k] <= '0;
      prod_vld_q <= 1'b0;
      sum        <= '0;
      vld_out    <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < K; k++) begin
        prod_q[k] <= PW'($signed(win[k])) * PW'($signed(wts[k]));
      end
      prod_vld_q <= vld_in & ~clr;
      sum        <= acc;
      vld_out    <= prod_vld_q & ~clr;
    end
  end

endmodule

// File: rtl/cnn_conv1d.sv
// Streaming 1-D convolution: window, weights, fill FSM and requantisation.
// Optional ReLU after saturation when CNN_CONV1D_RELU_EN is defined.
module cnn_conv1d
  import cnn_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned WW    = 8,
  parameter int unsigned K     = 3,
  parameter int unsigned SHIFT = 0,
  localparam int unsigned AW    = acc_width(DW, WW, K),
  localparam int unsigned AddrW = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    in,
  input  logic             i_en,
  input  logic             clr,
  input  logic             w_we,
  input  logic [AddrW-1:0] w_addr,
  input  logic [WW-1:0]    w_data,
  output logic [DW-1:0]    out,
  output logic             o_en
);

  localparam int unsigned CntW = $clog2(K + 1);

  fill_state_t          state_q;
  logic [CntW-1:0]      cnt_q;
  logic [K-1:0][DW-1:0] win_q;
  logic [K-1:0][WW-1:0] w_q;
  logic                 win_vld_q;
  logic signed [AW-1:0] sum;
  logic                 sum_vld;
  logic signed [63:0]   rq;
  logic [DW-1:0]        res;

  // Tap 0 holds the newest sample; win_vld_q marks a sample that leaves the window full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      cnt_q     <= '0;
      win_q     <= '0;
      win_vld_q <= 1'b0;
    end else if (clr) begin
      state_q   <= EMPTY;
      cnt_q     <= '0;
      win_q     <= '0;
      win_vld_q <= 1'b0;
    end else begin
      win_vld_q <= 1'b0;
      if (i_en) begin
        win_q <= {win_q[K-2:0], in};
        case (state_q)
          EMPTY: begin
            state_q <= FILL;
            cnt_q   <= CntW'(1);
          end
          FILL: begin
            if (cnt_q == CntW'(K - 1)) begin
              state_q   <= RUN;
              win_vld_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          RUN:     win_vld_q <= 1'b1;
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q <= '0;
    end else if (w_we && (32'(w_addr) < K)) begin
      w_q[w_addr] <= w_data;
    end
  end

  cnn_mac_tree #(
    .DW (DW),
    .WW (WW),
    .K  (K)
  ) u_mac_tree (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .vld_in  (win_vld_q),
    .win     (win_q),
    .wts     (w_q),
    .sum     (sum),
    .vld_out (sum_vld)
  );

  always_comb begin
    rq  = round_sat(64'(sum), SHIFT, DW);
    res = DW'(rq);
`ifdef CNN_CONV1D_RELU_EN
    if (rq < 0) res = '0;
`else
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out  <= '0;
      o_en <= 1'b0;
    end else begin
      o_en <= sum_vld & ~clr;
      if (sum_vld && !clr) out <= res;
    end
  end

endmodule
